// File: rtl/vga_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_adapter_pkg
// Description : Shared constants and helpers for the VGA adapter.
//               - 640x480@60 Hz horizontal/vertical timing constants.
//               - Frame-buffer geometry derived from the resolution choice.
//                 The choice is encoded as a single "low resolution" bit.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_adapter_pkg;

    // Horizontal timing, in pixel clocks
    localparam int H_VISIBLE    = 640;
    localparam int H_FRONT      = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BACK       = 48;
    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    // Vertical timing, in lines
    localparam int V_VISIBLE    = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Width of the hc/vc scan counters (both totals fit in 10 bits)
    localparam int CNT_W = 10;

    // Frame-buffer geometry: lowres=1 selects 160x120, otherwise 320x240
    function automatic int fb_width(input bit lowres);
        return lowres ? 160 : 320;
    endfunction

    function automatic int fb_height(input bit lowres);
        return lowres ? 120 : 240;
    endfunction

    function automatic int fb_xw(input bit lowres);
        return lowres ? 8 : 9;
    endfunction

    function automatic int fb_yw(input bit lowres);
        return lowres ? 7 : 8;
    endfunction

    // Screen-to-buffer shift: each buffer pixel covers 2^S x 2^S screen pixels
    function automatic int fb_shift(input bit lowres);
        return lowres ? 2 : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Pixel-clock divider, hc/vc scan counters, raw sync/blank
//               decode and frame-buffer read address.
//   clock       in   system clock
//   resetn      in   synchronous active-low reset
//   o_clk_div   out  clock/2 divider. It is also the pixel-advance enable.
//   o_hs_n      out  horizontal sync for the current counters (active low)
//   o_vs_n      out  vertical sync for the current counters (active low)
//   o_blank_n   out  high while the counters are in the visible region
//   o_rd_addr   out  buffer address of the pixel under the counters
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_adapter_pkg::*;
#(
    parameter bit LOWRES = 1'b0,
    parameter int ADDR_W = 17
) (
    input  logic              clock,
    input  logic              resetn,
    output logic              o_clk_div,
    output logic              o_hs_n,
    output logic              o_vs_n,
    output logic              o_blank_n,
    output logic [ADDR_W-1:0] o_rd_addr
);

    localparam int c_W     = fb_width(LOWRES);
    localparam int c_S     = fb_shift(LOWRES);

    localparam logic [CNT_W-1:0] c_H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_VIS      = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] c_V_VIS      = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] c_HS_START   = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0] c_HS_END     = CNT_W'(H_SYNC_END);
    localparam logic [CNT_W-1:0] c_VS_START   = CNT_W'(V_SYNC_START);
    localparam logic [CNT_W-1:0] c_VS_END     = CNT_W'(V_SYNC_END);

    logic             r_clk_div;
    logic [CNT_W-1:0] r_hc;
    logic [CNT_W-1:0] r_vc;

    // Counters move on the edge where the divider falls, so everything
    // derived from them is settled by the next rising edge of VGA_CLK.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_clk_div <= 1'b0;
            r_hc      <= '0;
            r_vc      <= '0;
        end else begin
            r_clk_div <= ~r_clk_div;
            if (r_clk_div) begin
                if (r_hc == c_H_LAST) begin
                    r_hc <= '0;
                    if (r_vc == c_V_LAST) begin
                        r_vc <= '0;
                    end else begin
                        r_vc <= r_vc + 1'b1;
                    end
                end else begin
                    r_hc <= r_hc + 1'b1;
                end
            end
        end
    end

    assign o_clk_div = r_clk_div;
    assign o_hs_n    = !((r_hc >= c_HS_START) && (r_hc < c_HS_END));
    assign o_vs_n    = !((r_vc >= c_VS_START) && (r_vc < c_VS_END));
    assign o_blank_n = (r_hc < c_H_VIS) && (r_vc < c_V_VIS);

    // During blanking this can point past the buffer; the data read there is
    // discarded because the output stage forces black while blanked.
    assign o_rd_addr = ADDR_W'(r_vc >> c_S) * ADDR_W'(c_W) + ADDR_W'(r_hc >> c_S);

endmodule
`default_nettype wire

// File: rtl/vga_adapter.sv
`default_nettype none
// ============================================================================
// Module      : vga_adapter
// Description : Frame buffer with 640x480@60 Hz VGA scan-out.
//               Each buffer pixel is replicated 2x2 (320x240) or 4x4 (160x120).
//   clock        in   50 MHz system clock
//   resetn       in   synchronous active-low reset (buffer contents survive)
//   colour       in   pixel colour, R,G,B fields MSB..LSB (1 bit if mono)
//   x, y         in   write coordinates; out-of-range writes are dropped
//   plot         in   write strobe, level sensitive
//   VGA_R/G/B    out  8-bit DAC channels, black while blanked
//   VGA_HS/VS    out  active-low syncs, aligned with RGB
//   VGA_BLANK_N  out  high in the visible region, aligned with RGB
//   VGA_SYNC_N   out  tied high
//   VGA_CLK      out  25 MHz pixel clock (clock/2)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_adapter
    import vga_adapter_pkg::*;
#(
    parameter string RESOLUTION              = "320x240",
    parameter string MONOCHROME              = "FALSE",
    parameter int    BITS_PER_COLOUR_CHANNEL = 1,
    localparam bit   c_LOWRES = (RESOLUTION == "160x120"),
    localparam bit   c_MONO   = (MONOCHROME == "TRUE"),
    localparam int   c_CW     = c_MONO ? 1 : 3 * BITS_PER_COLOUR_CHANNEL,
    localparam int   c_XW     = fb_xw(c_LOWRES),
    localparam int   c_YW     = fb_yw(c_LOWRES)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [c_CW-1:0] colour,
    input  logic [c_XW-1:0] x,
    input  logic [c_YW-1:0] y,
    input  logic            plot,
    output logic [7:0]      VGA_R,
    output logic [7:0]      VGA_G,
    output logic [7:0]      VGA_B,
    output logic            VGA_HS,
    output logic            VGA_VS,
    output logic            VGA_BLANK_N,
    output logic            VGA_SYNC_N,
    output logic            VGA_CLK
);

    localparam int c_W      = fb_width(c_LOWRES);
    localparam int c_H      = fb_height(c_LOWRES);
    localparam int c_DEPTH  = c_W * c_H;
    localparam int c_ADDR_W = $clog2(c_DEPTH);
    localparam int c_BPC    = BITS_PER_COLOUR_CHANNEL;

    localparam logic [c_XW-1:0] c_X_LIMIT = c_XW'(c_W);
    localparam logic [c_YW-1:0] c_Y_LIMIT = c_YW'(c_H);

    // ------------------------------------------------------------------
    // Timing generator
    // ------------------------------------------------------------------
    logic                w_pix_en;
    logic                w_hs_n;
    logic                w_vs_n;
    logic                w_blank_n;
    logic [c_ADDR_W-1:0] w_rd_addr;

    vga_timing_gen #(
        .LOWRES (c_LOWRES),
        .ADDR_W (c_ADDR_W)
    ) u_timing (
        .clock     (clock),
        .resetn    (resetn),
        .o_clk_div (w_pix_en),
        .o_hs_n    (w_hs_n),
        .o_vs_n    (w_vs_n),
        .o_blank_n (w_blank_n),
        .o_rd_addr (w_rd_addr)
    );

    // ------------------------------------------------------------------
    // Frame buffer: one write port, one synchronous read port. It is left
    // out of reset so a reset does not erase the picture.
    // ------------------------------------------------------------------
    logic [c_CW-1:0]     r_mem [0:c_DEPTH-1];
    logic [c_CW-1:0]     r_rd_data;
    logic                w_wr_en;
    logic [c_ADDR_W-1:0] w_wr_addr;

    assign w_wr_en   = plot && (x < c_X_LIMIT) && (y < c_Y_LIMIT);
    assign w_wr_addr = c_ADDR_W'(y) * c_ADDR_W'(c_W) + c_ADDR_W'(x);

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= colour;
        end
    end

    // Read is paced by the pixel enable so the RAM output acts as the first
    // pipeline stage. A write to the same address on the same edge is not
    // visible here; the old word is returned.
    always_ff @(posedge clock) begin
        if (w_pix_en) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Colour expansion: each channel field is repeated MSB-first to 8 bits
    // ------------------------------------------------------------------
    logic [7:0] w_r_exp;
    logic [7:0] w_g_exp;
    logic [7:0] w_b_exp;

    generate
        if (c_MONO) begin : g_mono
            assign w_r_exp = {8{r_rd_data[0]}};
            assign w_g_exp = {8{r_rd_data[0]}};
            assign w_b_exp = {8{r_rd_data[0]}};
        end else begin : g_rgb
            for (genvar i = 0; i < 8; i++) begin : g_bit
                assign w_r_exp[7-i] = r_rd_data[3*c_BPC - 1 - (i % c_BPC)];
                assign w_g_exp[7-i] = r_rd_data[2*c_BPC - 1 - (i % c_BPC)];
                assign w_b_exp[7-i] = r_rd_data[1*c_BPC - 1 - (i % c_BPC)];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output pipeline: sync/blank take one stage to match the RAM read,
    // then everything lands in the output register together.
    // ------------------------------------------------------------------
    logic       r_hs_d1;
    logic       r_vs_d1;
    logic       r_blank_n_d1;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank_n;
    logic [7:0] r_r;
    logic [7:0] r_g;
    logic [7:0] r_b;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_hs_d1      <= 1'b1;
            r_vs_d1      <= 1'b1;
            r_blank_n_d1 <= 1'b0;
            r_hs         <= 1'b1;
            r_vs         <= 1'b1;
            r_blank_n    <= 1'b0;
            r_r          <= 8'h00;
            r_g          <= 8'h00;
            r_b          <= 8'h00;
        end else if (w_pix_en) begin
            r_hs_d1      <= w_hs_n;
            r_vs_d1      <= w_vs_n;
            r_blank_n_d1 <= w_blank_n;
            r_hs         <= r_hs_d1;
            r_vs         <= r_vs_d1;
            r_blank_n    <= r_blank_n_d1;
            r_r          <= r_blank_n_d1 ? w_r_exp : 8'h00;
            r_g          <= r_blank_n_d1 ? w_g_exp : 8'h00;
            r_b          <= r_blank_n_d1 ? w_b_exp : 8'h00;
        end
    end

    assign VGA_R       = r_r;
    assign VGA_G       = r_g;
    assign VGA_B       = r_b;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_CLK     = w_pix_en;

endmodule
`default_nettype wire

// File: tb/tb_vga_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_adapter
// Description : Self-checking bench for vga_adapter (320x240, 3-bit colour).
//               A picture is loaded with random and tabulated writes. The
//               adapter is then reset mid-line. The first 15 scan lines are
//               compared, clock by clock, against a model of the screen that
//               is computed from the video timing and a frame-buffer array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_adapter;

    logic       clock = 1'b0;
    logic       resetn;
    logic [2:0] colour;
    logic [8:0] x;
    logic [7:0] y;
    logic       plot;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;

    vga_adapter dut (
        .clock       (clock),
        .resetn      (resetn),
        .colour      (colour),
        .x           (x),
        .y           (y),
        .plot        (plot),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .VGA_CLK     (VGA_CLK)
    );

    always #5 clock = ~clock;

    // {VGA_CLK, HS, VS, BLANK_N, SYNC_N, R, G, B}
    logic [28:0] dut_bus;
    assign dut_bus = {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
                      VGA_R, VGA_G, VGA_B};

    localparam logic [28:0] c_RESET_BUS = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 24'h0};

    int n_vec = 0;
    int n_err = 0;

    // Clocks seen with resetn high since the last reset
    int ncyc = 0;
    always @(posedge clock) begin
        if (resetn) ncyc <= ncyc + 1;
        else        ncyc <= 0;
    end

    // Reference frame buffer (starts black) and captured screen RGB
    int          model_mem [320*240];
    logic [23:0] cap [16*800];

    typedef struct {
        int          x;
        int          y;
        int          c;
        int          phc;   // top-left screen pixel to probe
        int          pvc;
        logic [23:0] exp;   // required RGB over the 2x2 probe block
    } wr_vec_t;

    wr_vec_t tbl [7];

    function automatic logic [23:0] expand3(input int c);
        logic [23:0] v;
        v[23:16] = c[2] ? 8'hFF : 8'h00;
        v[15:8]  = c[1] ? 8'hFF : 8'h00;
        v[7:0]   = c[0] ? 8'hFF : 8'h00;
        return v;
    endfunction

    // Expected output bus after the n-th clock since reset release. The
    // divider toggles each clock. The screen lags the scan by two pixel
    // periods; pixel p is on screen from clock 2p+4.
    function automatic logic [28:0] exp_bus(input int n);
        int          p, hc, vc;
        logic        vclk, blank_n, hs, vs;
        logic [23:0] rgb;
        vclk = (n % 2) == 1;
        if (n < 4) return {vclk, 1'b1, 1'b1, 1'b0, 1'b1, 24'h0};
        p       = (n - 4) / 2;
        hc      = p % 800;
        vc      = (p / 800) % 525;
        blank_n = (hc < 640) && (vc < 480);
        hs      = !((hc >= 656) && (hc < 752));
        vs      = !((vc >= 490) && (vc < 492));
        rgb     = blank_n ? expand3(model_mem[(vc / 2) * 320 + hc / 2]) : 24'h0;
        return {vclk, hs, vs, blank_n, 1'b1, rgb};
    endfunction

    task automatic check(input string name, input logic [28:0] act,
                         input logic [28:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (t=%0t ncyc=%0d): got %h, expected %h",
                     name, $time, ncyc, act, exp);
        end
    endtask

    // One-clock write; the model ignores out-of-range coordinates
    task automatic wr(input int xi, input int yi, input int ci);
        x      = 9'(xi);
        y      = 8'(yi);
        colour = 3'(ci);
        plot   = 1'b1;
        @(negedge clock);
        plot   = 1'b0;
        if (xi < 320 && yi < 240) model_mem[yi*320 + xi] = ci;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        tbl[0] = '{x:0,   y:0,   c:2, phc:0,   pvc:0,  exp:24'h00FF00};
        tbl[1] = '{x:319, y:6,   c:7, phc:638, pvc:12, exp:24'hFFFFFF};
        tbl[2] = '{x:320, y:0,   c:7, phc:0,   pvc:2,  exp:24'h000000};
        tbl[3] = '{x:1,   y:240, c:7, phc:2,   pvc:0,  exp:24'h000000};
        tbl[4] = '{x:3,   y:2,   c:5, phc:6,   pvc:4,  exp:24'hFF00FF};
        tbl[5] = '{x:319, y:0,   c:3, phc:638, pvc:0,  exp:24'h00FFFF};
        tbl[6] = '{x:511, y:3,   c:6, phc:382, pvc:8,  exp:24'h000000};
        for (int i = 0; i < 320*240; i++) model_mem[i] = 0;

        resetn = 1'b0; plot = 1'b0; x = '0; y = '0; colour = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_state", dut_bus, c_RESET_BUS);

        resetn = 1'b1;

        // Random in-range writes, kept clear of the probe columns
        for (int i = 0; i < 40; i++)
            wr($urandom_range(180, 8), $urandom_range(6, 0), $urandom_range(7, 0));
        // Random out-of-range writes
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(1, 0) == 1)
                wr($urandom_range(511, 320), $urandom_range(255, 0), $urandom_range(7, 1));
            else
                wr($urandom_range(319, 0), $urandom_range(255, 240), $urandom_range(7, 1));
        end
        // Tabulated writes (boundaries, out-of-range aliases)
        for (int i = 0; i < 7; i++) wr(tbl[i].x, tbl[i].y, tbl[i].c);

        // Plot held high across two clocks at one address: last value wins
        x = 9'd5; y = 8'd5; colour = 3'b001; plot = 1'b1;
        @(negedge clock);
        colour = 3'b100;
        @(negedge clock);
        plot = 1'b0;
        model_mem[5*320 + 5] = 1;
        model_mem[5*320 + 5] = 4;

        // Mid-line: the visible part of line 0 is on screen here
        while (ncyc < 300) @(negedge clock);
        check("pre_reset_midline", dut_bus, exp_bus(ncyc));

        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("mid_reset", dut_bus, c_RESET_BUS);
        end
        resetn = 1'b1;

        // Full-bus scan of lines 0..14 after restart
        for (int i = 0; i < 15*1600 + 4; i++) begin
            @(negedge clock);
            check("scan", dut_bus, exp_bus(ncyc));
            if ((ncyc % 2) == 1 && ncyc >= 4 && (ncyc - 4) / 2 < 16*800)
                cap[(ncyc - 4) / 2] = {VGA_R, VGA_G, VGA_B};
        end

        // Probe the 2x2 screen blocks of the tabulated writes
        for (int i = 0; i < 7; i++)
            for (int dy = 0; dy < 2; dy++)
                for (int dx = 0; dx < 2; dx++) begin
                    idx = (tbl[i].pvc + dy) * 800 + tbl[i].phc + dx;
                    check("probe_tbl", {5'b0, cap[idx]}, {5'b0, tbl[i].exp});
                end
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
                check("probe_overwrite", {5'b0, cap[(10 + dy) * 800 + 10 + dx]},
                      {5'b0, 24'hFF0000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
